gray_unwrap_multi: RTL and testbench
====================================

Name: gray_unwrap_multi

Overview:
- Multi-channel, parametrised Gray-to-extended-binary unwrapper for free-running Gray-coded counters, e.g. ring-oscillator or VCO phase counters sampled in the CLK_24M domain.
- Per channel: converts a GRAY_W-bit Gray sample to binary and keeps an EXT_W-bit signed-wrap extension, so the output is a monotonic (GRAY_W+EXT_W)-bit count.
- Successor to the single-channel up-only unwrapper. Adds:
  - channel count parameter
  - quadrant-based bidirectional wrap detection
  - first-sample priming
  - skip (jump) detection
  - sticky overflow
  - registered outputs with a valid strobe

Parameters:
CHANNELS, 4, number of independent counter channels.
GRAY_W, 6, Gray input width per channel (>=3).
EXT_W, 6, extension width per channel.
BIDIR, 1, 1 = detect backward wraps (decrement extension); 0 = forward wraps only.

Ports:
CLK_24M  in  1  system clock, rising edge.
reset  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of all channel state (priority over sample_valid).
sample_valid  in  1  gray bus holds a new sample for all channels this cycle.
gray  in  CHANNELS*GRAY_W  Gray samples; channel c at bits [c*GRAY_W +: GRAY_W].
bin_extended  out  CHANNELS*(GRAY_W+EXT_W)  per channel {extension, binary}; channel c at [c*(GRAY_W+EXT_W) +: GRAY_W+EXT_W].
out_valid  out  1  one-cycle pulse: bin_extended updated.
wrap_up  out  CHANNELS  one-cycle pulse per channel: forward wrap applied.
wrap_dn  out  CHANNELS  one-cycle pulse per channel: backward wrap applied (always 0 when BIDIR=0).
overflow  out  CHANNELS  sticky: extension wrapped modulo 2^EXT_W.
jump_err  out  CHANNELS  sticky: quadrant skip detected.

Behaviour:
- Reset (reset=0, async): all per-channel state zero, primed=0 per channel; all outputs 0. Registers never update in the reset phase.
- Binary conversion, combinational per channel: b[GRAY_W-1]=g[GRAY_W-1]; b[i]=b[i+1]^g[i].
- Quadrant: q = b[GRAY_W-1:GRAY_W-2]. The previous binary and quadrant are stored per channel.
- On a cycle with sample_valid=1 and clear=0, each channel computes:
  - primed=0: no wrap evaluation; store binary, set primed=1, extension unchanged.
  - prev q=3, new q=0: extension+1, wrap_up pulse.
  - prev q=0, new q=3, BIDIR=1: extension-1, wrap_dn pulse.
  - prev q=0, new q=3, BIDIR=0: no extension change, no pulse.
  - |new q - prev q| = 2 (0<->2, 1<->3): jump_err set; extension unchanged; binary still stored.
  - otherwise: extension unchanged.
- Extension arithmetic is modulo 2^EXT_W:
  - 2^EXT_W-1 -> 0 on increment sets overflow.
  - 0 -> 2^EXT_W-1 on decrement sets overflow.
- Latency: bin_extended, wrap_up and wrap_dn are registered and appear one cycle after the sampling edge; out_valid pulses on the same cycle. Between samples the outputs hold, and wrap pulses are 0.
- sample_valid=0: no state change.
- clear=1: extension, stored binary, primed, overflow, jump_err and bin_extended go to 0; out_valid=0 next cycle. A simultaneous sample_valid is discarded.
- Channels are fully independent; identical timing for all channels.
- Async reset mid-operation forces the reset state immediately. The first sample after release only primes the channel.

Test Plan (CHANNELS=4, GRAY_W=6, EXT_W=6, BIDIR=1 unless stated):
1. Reset release; ch0 samples binary 60 (gray 6'b100010), then binary 2 (gray 6'b000011) -> after the 2nd sample, ch0 bin_extended=12'h042, wrap_up[0] pulses once, out_valid pulses, other channels unaffected.
2. Forward wrap to ext=1, then ch0 samples binary 60 (q 0->3) -> bin_extended=12'h03C, wrap_dn[0] pulses. Another q 0->3 crossing -> ext=63, overflow[0]=1.
3. Drive 64 forward wraps on ch1 -> ext 63 -> 0 with overflow[1]=1 sticky; repeat with BIDIR=0 and backward crossings -> ext never decrements, wrap_dn=0.
4. ch2 binary 0 then binary 32 (gray 6'b110000) -> jump_err[2]=1, ext unchanged, bin_extended low bits=32.
5. First sample after reset is binary 2 (q=0) and the previous stored value is 0 -> no wrap: bin_extended=12'h002. Same for the first sample after clear.
6. clear asserted with sample_valid=1 while ext=5 and overflow=1 -> next cycle all outputs 0, out_valid=0. Async reset asserted between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/gray_unwrap_multi.sv
// gray_unwrap_multi
//
// Unwraps several free-running Gray-coded counters (ring-oscillator or VCO
// phase counters sampled in the CLK_24M domain) into monotonic extended
// binary counts. Each channel decodes its GRAY_W-bit Gray sample to binary and
// keeps an EXT_W-bit signed-wrap extension above it. Wraps are found by
// comparing the top two binary bits (the quadrant) of the new sample against
// the stored previous sample:
//   q 3 -> 0 : forward wrap, extension + 1
//   q 0 -> 3 : backward wrap, extension - 1 (only when BIDIR != 0)
//   q differs by 2 : a quadrant was skipped, so the wrap direction is
//                    unknowable; flag jump_err and leave the extension alone.
// The first sample after reset or clear only primes the channel. Before
// priming there is no trustworthy previous value to compare against.
//
// Handshake: there is no back-pressure. sample_valid qualifies the gray bus for
// exactly the cycle it is high. out_valid pulses one cycle after every
// accepted sample, on the same cycle that bin_extended and the wrap pulses
// reflect that sample. A cycle with clear=1 accepts no sample.
//
// Ports:
//   CLK_24M       system clock, rising edge
//   reset         asynchronous active-low reset
//   clear         synchronous clear of all channel state, wins over sample_valid
//   sample_valid  gray holds a new sample for every channel this cycle
//   gray          channel c Gray sample at [c*GRAY_W +: GRAY_W]
//   bin_extended  channel c {extension, binary} at [c*(GRAY_W+EXT_W) +: ...]
//   out_valid     one-cycle pulse: bin_extended updated
//   wrap_up       per-channel one-cycle pulse: forward wrap applied
//   wrap_dn       per-channel one-cycle pulse: backward wrap applied
//   overflow      per-channel sticky: extension wrapped modulo 2^EXT_W
//   jump_err      per-channel sticky: quadrant skip seen
//
// GRAY_W must be at least 3 so that a quadrant spans more than one code.

module gray_unwrap_multi #(
  parameter int CHANNELS = 4,
  parameter int GRAY_W   = 6,
  parameter int EXT_W    = 6,
  parameter int BIDIR    = 1
) (
  input  logic                                CLK_24M,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                sample_valid,
  input  logic [CHANNELS*GRAY_W-1:0]          gray,
  output logic [CHANNELS*(GRAY_W+EXT_W)-1:0]  bin_extended,
  output logic                                out_valid,
  output logic [CHANNELS-1:0]                 wrap_up,
  output logic [CHANNELS-1:0]                 wrap_dn,
  output logic [CHANNELS-1:0]                 overflow,
  output logic [CHANNELS-1:0]                 jump_err
);

  localparam int OUT_W = GRAY_W + EXT_W;

  // Shared for all channels: every channel samples on the same cycle.
  logic take;
  assign take = sample_valid && !clear;

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= take;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [GRAY_W-1:0] g_now;
    logic [GRAY_W-1:0] b_now;
    logic [GRAY_W-1:0] bin_q;
    logic [EXT_W-1:0]  ext_q;
    logic              primed_q;
    logic              up_q;
    logic              dn_q;
    logic              ovf_q;
    logic              jerr_q;
    logic [1:0]        q_now;
    logic [1:0]        q_prev;
    logic              is_up;
    logic              is_dn;
    logic              is_jump;

    assign g_now = gray[c*GRAY_W +: GRAY_W];

    // Binary bit i is the XOR of all Gray bits from i upward.
    always_comb begin
      b_now = '0;
      for (int i = 0; i < GRAY_W; i++) begin
        b_now[i] = ^(g_now >> i);
      end
    end

    assign q_now  = b_now[GRAY_W-1 -: 2];
    assign q_prev = bin_q[GRAY_W-1 -: 2];

    always_comb begin
      is_up   = primed_q && (q_prev == 2'b11) && (q_now == 2'b00);
      is_dn   = (BIDIR != 0) && primed_q && (q_prev == 2'b00) && (q_now == 2'b11);
      // A quadrant distance of two shows up as XOR 2'b10 (0<->2, 1<->3).
      is_jump = primed_q && ((q_prev ^ q_now) == 2'b10);
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
      if (!reset) begin
        bin_q    <= '0;
        ext_q    <= '0;
        primed_q <= 1'b0;
        up_q     <= 1'b0;
        dn_q     <= 1'b0;
        ovf_q    <= 1'b0;
        jerr_q   <= 1'b0;
      end else if (clear) begin
        bin_q    <= '0;
        ext_q    <= '0;
        primed_q <= 1'b0;
        up_q     <= 1'b0;
        dn_q     <= 1'b0;
        ovf_q    <= 1'b0;
        jerr_q   <= 1'b0;
      end else if (sample_valid) begin
        // The binary is always stored, even on a skip, so tracking resumes
        // from the latest position.
        bin_q    <= b_now;
        primed_q <= 1'b1;
        up_q     <= is_up;
        dn_q     <= is_dn;
        if (is_up) begin
          ext_q <= ext_q + 1'b1;
          if (ext_q == '1) begin
            ovf_q <= 1'b1;
          end
        end else if (is_dn) begin
          ext_q <= ext_q - 1'b1;
          if (ext_q == '0) begin
            ovf_q <= 1'b1;
          end
        end
        if (is_jump) begin
          jerr_q <= 1'b1;
        end
      end else begin
        // Between samples the count holds and the wrap pulses drop.
        up_q <= 1'b0;
        dn_q <= 1'b0;
      end
    end

    // The stored extension and binary are the registered output.
    assign bin_extended[c*OUT_W +: OUT_W] = {ext_q, bin_q};
    assign wrap_up[c]  = up_q;
    assign wrap_dn[c]  = dn_q;
    assign overflow[c] = ovf_q;
    assign jump_err[c] = jerr_q;
  end

endmodule

// File: tb/tb_gray_unwrap_multi.sv
`timescale 1ns/1ps
module tb_gray_unwrap_multi;

  localparam int CH = 4;
  localparam int GW = 6;
  localparam int XW = 6;
  localparam int OW = GW + XW;
  localparam int BW = CH * OW;
  localparam int EW = BW + 4*CH + 1;

  // ---------------- clock / reset ----------------
  logic CLK_24M = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic sample_valid = 1'b0;
  logic [CH*GW-1:0] gray = '0;

  always #20 CLK_24M = ~CLK_24M;

  // dut1: BIDIR=1, dut0: BIDIR=0, same stimulus
  logic [BW-1:0] be1, be0;
  logic          ov1, ov0;
  logic [CH-1:0] wu1, wd1, of1, je1;
  logic [CH-1:0] wu0, wd0, of0, je0;

  gray_unwrap_multi #(.CHANNELS(CH), .GRAY_W(GW), .EXT_W(XW), .BIDIR(1)) dut (
    .CLK_24M(CLK_24M), .reset(reset), .clear(clear), .sample_valid(sample_valid),
    .gray(gray), .bin_extended(be1), .out_valid(ov1), .wrap_up(wu1),
    .wrap_dn(wd1), .overflow(of1), .jump_err(je1)
  );

  gray_unwrap_multi #(.CHANNELS(CH), .GRAY_W(GW), .EXT_W(XW), .BIDIR(0)) dut_fwd (
    .CLK_24M(CLK_24M), .reset(reset), .clear(clear), .sample_valid(sample_valid),
    .gray(gray), .bin_extended(be0), .out_valid(ov0), .wrap_up(wu0),
    .wrap_dn(wd0), .overflow(of0), .jump_err(je0)
  );

  // ---------------- scoreboard / model ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [EW-1:0] exp_q[$];

  int cur_bin[CH];
  int m_ext[2][CH];
  int m_bin[2][CH];
  bit m_pr[2][CH];
  bit m_of[2][CH];
  bit m_je[2][CH];
  bit m_up[2][CH];
  bit m_dn[2][CH];
  bit m_ov[2];

  function automatic logic [GW-1:0] to_gray(input int b);
    logic [GW-1:0] x;
    x = GW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_ov[v] = 0;
      for (int c = 0; c < CH; c++) begin
        m_ext[v][c] = 0; m_bin[v][c] = 0; m_pr[v][c] = 0;
        m_of[v][c] = 0; m_je[v][c] = 0; m_up[v][c] = 0; m_dn[v][c] = 0;
      end
    end
  endtask

  // v=1 models the bidirectional DUT, v=0 the forward-only one.
  task automatic model_step(input bit clr, input bit sv);
    int qn, qp;
    for (int v = 0; v < 2; v++) begin
      m_ov[v] = sv && !clr;
      for (int c = 0; c < CH; c++) begin
        m_up[v][c] = 0;
        m_dn[v][c] = 0;
        if (clr) begin
          m_ext[v][c] = 0; m_bin[v][c] = 0; m_pr[v][c] = 0;
          m_of[v][c] = 0; m_je[v][c] = 0;
        end else if (sv) begin
          qn = cur_bin[c] / 16;
          qp = m_bin[v][c] / 16;
          if (m_pr[v][c]) begin
            if (qp == 3 && qn == 0) begin
              m_up[v][c] = 1;
              if (m_ext[v][c] == 63) begin m_ext[v][c] = 0; m_of[v][c] = 1; end
              else m_ext[v][c] = m_ext[v][c] + 1;
            end else if (qp == 0 && qn == 3 && v == 1) begin
              m_dn[v][c] = 1;
              if (m_ext[v][c] == 0) begin m_ext[v][c] = 63; m_of[v][c] = 1; end
              else m_ext[v][c] = m_ext[v][c] - 1;
            end else if (qn - qp == 2 || qp - qn == 2) begin
              m_je[v][c] = 1;
            end
          end
          m_bin[v][c] = cur_bin[c];
          m_pr[v][c] = 1;
        end
      end
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input int v);
    logic [EW-1:0] e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      e[c*OW +: OW]  = {XW'(m_ext[v][c]), GW'(m_bin[v][c])};
      e[BW + c]      = m_up[v][c];
      e[BW + CH + c] = m_dn[v][c];
      e[BW + 2*CH + c] = m_of[v][c];
      e[BW + 3*CH + c] = m_je[v][c];
    end
    e[EW-1] = m_ov[v];
    return e;
  endfunction

  function automatic logic [EW-1:0] pack_obs(input int v);
    if (v == 1) return {ov1, je1, of1, wd1, wu1, be1};
    else        return {ov0, je0, of0, wd0, wu0, be0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int v, input string tag);
    logic [EW-1:0] e, o;
    e = exp_q.pop_front();
    o = pack_obs(v);
    chk({tag, ".bin_extended"}, 64'(o[BW-1:0]), 64'(e[BW-1:0]));
    chk({tag, ".wrap_up"},  64'(o[BW +: CH]),        64'(e[BW +: CH]));
    chk({tag, ".wrap_dn"},  64'(o[BW+CH +: CH]),     64'(e[BW+CH +: CH]));
    chk({tag, ".overflow"}, 64'(o[BW+2*CH +: CH]),   64'(e[BW+2*CH +: CH]));
    chk({tag, ".jump_err"}, 64'(o[BW+3*CH +: CH]),   64'(e[BW+3*CH +: CH]));
    chk({tag, ".out_valid"}, 64'(o[EW-1]),           64'(e[EW-1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit clr, input bit sv);
    @(negedge CLK_24M);
    clear = clr;
    sample_valid = sv;
    for (int c = 0; c < CH; c++) gray[c*GW +: GW] = to_gray(cur_bin[c]);
    if (!reset) model_reset();
    else model_step(clr, sv);
    exp_q.push_back(pack_exp(1));
    exp_q.push_back(pack_exp(0));
    @(posedge CLK_24M);
    #1;
    check_dut(1, "bidir");
    check_dut(0, "fwd");
  endtask

  task automatic smp(input int ch, input int b);
    cur_bin[ch] = b;
    cyc(0, 1);
  endtask

  task automatic idle();
    cyc(0, 0);
  endtask

  // Reset asserted between clock edges must clear outputs without an edge.
  task automatic async_reset();
    @(posedge CLK_24M);
    #7;
    reset = 1'b0;
    #1;
    chk("areset.bidir_bin", 64'(be1), 64'd0);
    chk("areset.fwd_bin",   64'(be0), 64'd0);
    chk("areset.bidir_flags", 64'({ov1, je1, of1, wd1, wu1}), 64'd0);
    chk("areset.fwd_flags",   64'({ov0, je0, of0, wd0, wu0}), 64'd0);
    model_reset();
    cyc(0, 1);            // sample during reset is ignored
    reset = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int c = 0; c < CH; c++) cur_bin[c] = 0;
    model_reset();

    // reset phase: sample ignored, everything zero
    cyc(0, 1);
    reset = 1'b1;
    idle();

    // 1: forward wrap on ch0
    smp(0, 60);
    chk("t1.prime_bin", 64'(be1[11:0]), 64'h03C);
    smp(0, 2);
    chk("t1.bin",       64'(be1[11:0]), 64'h042);
    chk("t1.wrap_up",   64'(wu1), 64'b0001);
    chk("t1.others",    64'(be1[BW-1:OW]), 64'd0);
    idle();
    chk("t1.pulse_drop", 64'(wu1), 64'd0);

    // 2: backward wrap to 0, then underflow to 63
    smp(0, 60);
    chk("t2.bin",      64'(be1[11:0]), 64'h03C);
    chk("t2.wrap_dn",  64'(wd1), 64'b0001);
    chk("t2.fwd_bin",  64'(be0[11:0]), 64'h07C);
    smp(0, 40); smp(0, 20); smp(0, 2); smp(0, 60);
    chk("t2.under_bin", 64'(be1[11:0]), 64'hFFC);
    chk("t2.overflow",  64'(of1[0]), 64'd1);

    // 3: 64 forward wraps on ch1, then backward crossings
    for (int k = 0; k < 64; k++) begin
      smp(1, 16 + $urandom_range(0, 15));
      smp(1, 32 + $urandom_range(0, 15));
      smp(1, 48 + $urandom_range(0, 15));
      smp(1, $urandom_range(0, 15));
    end
    chk("t3.ext_zero", 64'(be1[2*OW-1 -: XW]), 64'd0);
    chk("t3.overflow", 64'(of1[1]), 64'd1);
    chk("t3.fwd_overflow", 64'(of0[1]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      smp(1, 60); smp(1, 40); smp(1, 20); smp(1, 2);
    end
    chk("t3.bidir_ext", 64'(be1[2*OW-1 -: XW]), 64'd61);
    chk("t3.fwd_ext",   64'(be0[2*OW-1 -: XW]), 64'd0);

    // 4: quadrant skip on ch2
    smp(2, 32);
    chk("t4.jump_err", 64'(je1[2]), 64'd1);
    chk("t4.bin",      64'(be1[3*OW-1 -: OW]), 64'h020);
    smp(2, 33);
    chk("t4.sticky",   64'(je1[2]), 64'd1);

    // 5: first sample after reset / clear only primes
    async_reset();
    smp(0, 2);
    chk("t5.reset_prime", 64'(be1[11:0]), 64'h002);
    chk("t5.no_wrap",     64'(wu1), 64'd0);
    smp(0, 60);
    cyc(1, 0);
    smp(0, 2);
    chk("t5.clear_prime", 64'(be1[11:0]), 64'h002);

    // 6: clear with a simultaneous sample, then async reset mid-cycle
    smp(3, 60);
    for (int k = 0; k < 6; k++) begin
      smp(3, 2); smp(3, 16); smp(3, 32); smp(3, 48);
    end
    chk("t6.ext5",     64'(be1[BW-1 -: XW]), 64'd5);
    chk("t6.overflow", 64'(of1[3]), 64'd1);
    cur_bin[3] = 7;
    cyc(1, 1);
    chk("t6.clear_bin",   64'(be1), 64'd0);
    chk("t6.clear_flags", 64'({ov1, je1, of1, wd1, wu1}), 64'd0);
    smp(3, 16); smp(3, 32);
    async_reset();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
